// File: rtl/pad_stream_feeder_pkg.sv
// Shared types and defaults for the padded stream feeder.
// The feeder reads one channel of a square feature map and streams it in raster order.
package pad_stream_feeder_pkg;

   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_ADDR_WIDTH = 16;
   localparam int DEF_PAD_VALUE  = 0;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } feeder_state_t;

   // Edge length of the frame actually emitted, border included.
   function automatic logic [8:0] padded_dim(input logic [7:0] dim, input logic pad);
      return {1'b0, dim} + {7'b0, pad, 1'b0};
   endfunction

endpackage

// File: rtl/pad_stream_feeder_if.sv
// RAM read port plus pixel stream between the feeder (master) and RAM/window generator (slave).
interface pad_stream_feeder_if
   import pad_stream_feeder_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) ();

   logic                  mem_rd_en;
   logic [ADDR_WIDTH-1:0] mem_rd_addr;
   logic [DATA_WIDTH-1:0] mem_rd_data;

   // Stream: a pixel moves when new_data_valid && in_rd_en on a rising edge. Once raised,
   // new_data_valid and new_data hold until that transfer; valid never looks at in_rd_en,
   // while in_rd_en may depend combinationally on valid.
   logic [DATA_WIDTH-1:0] new_data;
   logic                  new_data_valid;
   logic                  in_rd_en;

   modport master (
      output mem_rd_en, mem_rd_addr, new_data, new_data_valid,
      input  mem_rd_data, in_rd_en
   );

   modport slave (
      input  mem_rd_en, mem_rd_addr, new_data, new_data_valid,
      output mem_rd_data, in_rd_en
   );

endinterface

// File: rtl/pad_stream_feeder_skid_fifo.sv
// Two-entry FIFO that absorbs the one-cycle RAM latency so the stream can run at full rate.
module feeder_skid_fifo
   import pad_stream_feeder_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  i_push,
   input  logic [DATA_WIDTH-1:0] i_push_data,
   input  logic                  i_pop,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic [1:0]            o_count
);

   logic [DATA_WIDTH-1:0] r_mem [2];
   logic                  r_wr_ptr;
   logic                  r_rd_ptr;
   logic [1:0]            r_count;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (i_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
            r_wr_ptr        <= ~r_wr_ptr;
         end
         if (i_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_data  = r_mem[r_rd_ptr];
   assign o_count = r_count;

endmodule

// File: rtl/pad_stream_feeder.sv
// Raster-order feeder: walks (dim+2*pad)^2 positions, reads interior pixels from RAM,
// substitutes PAD_VALUE on the border, and streams through a 2-entry skid FIFO.
module pad_stream_feeder
   import pad_stream_feeder_pkg::*;
#(
   parameter int                    DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int                    ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter logic [DATA_WIDTH-1:0] PAD_VALUE  = DATA_WIDTH'(DEF_PAD_VALUE)
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic [7:0]            input_dim,
   input  logic                  pad_en,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   output logic                  busy,
   output logic                  done,
   output feeder_state_t         o_dbg_state,
   pad_stream_feeder_if.master   bus
);

   feeder_state_t         r_state;
   feeder_state_t         w_state_nxt;
   logic [8:0]            r_dim_p;
   logic                  r_pad;
   logic [8:0]            r_row;
   logic [8:0]            r_col;
   logic [ADDR_WIDTH-1:0] r_ptr;
   logic                  r_tag_valid;
   logic                  r_tag_pad;

   logic                  w_start_ok;
   logic [8:0]            w_in_p;
   logic [8:0]            w_cur_p;
   logic                  w_cur_pad;
   logic [8:0]            w_cur_row;
   logic [8:0]            w_cur_col;
   logic [ADDR_WIDTH-1:0] w_cur_ptr;
   logic                  w_active;
   logic [1:0]            w_fifo_count;
   logic [DATA_WIDTH-1:0] w_fifo_data;
   logic                  w_valid;
   logic                  w_pop;
   logic [2:0]            w_occ;
   logic                  w_issue;
   logic                  w_last_row;
   logic                  w_last_col;
   logic                  w_border;
   logic                  w_rd;
   logic                  w_drained;
   logic                  w_done;
   logic [DATA_WIDTH-1:0] w_push_data;

   assign w_start_ok = (r_state == IDLE) && start;
   assign w_in_p     = padded_dim(input_dim, pad_en);

   // Position (0,0) is issued in the start cycle itself, straight from the start-time inputs.
   assign w_cur_p   = (r_state == IDLE) ? w_in_p    : r_dim_p;
   assign w_cur_pad = (r_state == IDLE) ? pad_en    : r_pad;
   assign w_cur_row = (r_state == IDLE) ? 9'd0      : r_row;
   assign w_cur_col = (r_state == IDLE) ? 9'd0      : r_col;
   assign w_cur_ptr = (r_state == IDLE) ? base_addr : r_ptr;

   assign w_valid = (w_fifo_count != 2'd0);
   assign w_pop   = w_valid && bus.in_rd_en;

   // A pop in this cycle frees a slot, which keeps the stream at one pixel per cycle.
   assign w_occ    = {1'b0, w_fifo_count} + {2'b0, r_tag_valid} - {2'b0, w_pop};
   assign w_active = !reset && ((r_state == RUN) || (w_start_ok && (w_in_p != 9'd0)));
   assign w_issue  = w_active && (w_occ < 3'd2);

   assign w_last_row = (w_cur_row == w_cur_p - 9'd1);
   assign w_last_col = (w_cur_col == w_cur_p - 9'd1);
   assign w_border   = w_cur_pad && ((w_cur_row == 9'd0) || w_last_row ||
                                     (w_cur_col == 9'd0) || w_last_col);
   assign w_rd       = w_issue && !w_border;
   assign w_drained  = (w_fifo_count == 2'd0) && !r_tag_valid;

   always_comb begin
      w_state_nxt = r_state;
      w_done      = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               if (w_in_p == 9'd0) begin
                  w_state_nxt = DRAIN;
               end else if (w_issue && w_last_row && w_last_col) begin
                  w_state_nxt = DRAIN;
               end else begin
                  w_state_nxt = RUN;
               end
            end
         end
         RUN: begin
            if (w_issue && w_last_row && w_last_col) begin
               w_state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            if (w_drained) begin
               w_state_nxt = IDLE;
               w_done      = 1'b1;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state     <= IDLE;
         r_dim_p     <= 9'd0;
         r_pad       <= 1'b0;
         r_row       <= 9'd0;
         r_col       <= 9'd0;
         r_ptr       <= '0;
         r_tag_valid <= 1'b0;
         r_tag_pad   <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_tag_valid <= w_issue;
         r_tag_pad   <= w_border;
         if (w_start_ok) begin
            r_dim_p <= w_in_p;
            r_pad   <= pad_en;
            r_row   <= 9'd0;
            r_col   <= 9'd0;
            r_ptr   <= base_addr;
         end
         if (w_issue) begin
            r_row <= w_last_col ? w_cur_row + 9'd1 : w_cur_row;
            r_col <= w_last_col ? 9'd0 : w_cur_col + 9'd1;
            r_ptr <= w_border ? w_cur_ptr : w_cur_ptr + 1'b1;
         end
      end
   end

   assign w_push_data = r_tag_pad ? PAD_VALUE : bus.mem_rd_data;

   feeder_skid_fifo #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_fifo (
      .clock       (clock),
      .reset       (reset),
      .i_push      (r_tag_valid),
      .i_push_data (w_push_data),
      .i_pop       (w_pop),
      .o_data      (w_fifo_data),
      .o_count     (w_fifo_count)
   );

   assign bus.mem_rd_en      = w_rd;
   assign bus.mem_rd_addr    = w_rd ? w_cur_ptr : '0;
   assign bus.new_data       = w_fifo_data;
   assign bus.new_data_valid = w_valid;

   assign busy        = (r_state != IDLE);
   assign done        = w_done && !reset;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_pad_stream_feeder.sv
// Self-checking bench for pad_stream_feeder: RAM model, reference raster model, scoreboard.
module tb_pad_stream_feeder;
   import pad_stream_feeder_pkg::*;

   localparam int DW = 8;
   localparam int AW = 16;

   logic          clock = 1'b0;
   logic          reset;
   logic          start;
   logic [7:0]    input_dim;
   logic          pad_en;
   logic [AW-1:0] base_addr;
   logic          busy;
   logic          done;
   feeder_state_t dbg_state;

   pad_stream_feeder_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   pad_stream_feeder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clock       (clock),
      .reset       (reset),
      .start       (start),
      .input_dim   (input_dim),
      .pad_en      (pad_en),
      .base_addr   (base_addr),
      .busy        (busy),
      .done        (done),
      .o_dbg_state (dbg_state),
      .bus         (bus.master)
   );

   always #5 clock = ~clock;

   logic [DW-1:0] ram [0:65535];

   always @(posedge clock) begin
      if (bus.mem_rd_en) bus.mem_rd_data <= ram[bus.mem_rd_addr];
   end

   int            n_chk = 0;
   int            n_bad = 0;
   int            cyc = 0;
   int            rd_mode = 0;
   logic [DW-1:0] exp_q[$];
   int            xfer_cnt, rd_cnt, done_cnt;
   int            first_valid_cyc, last_xfer_cyc, done_cyc;
   logic [AW-1:0] rd_base, last_rd_addr;
   logic          prev_stall;
   logic [DW-1:0] prev_data;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic monitor_cycle();
      @(negedge clock);
      if (!reset) begin
         if (prev_stall) begin
            check_val("hold_valid", {31'b0, bus.new_data_valid}, 32'd1);
            check_val("hold_data", {24'b0, bus.new_data}, {24'b0, prev_data});
         end
         if (bus.new_data_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
         if (bus.new_data_valid && bus.in_rd_en) begin
            if (exp_q.size() == 0) check_val("extra_pixel", exp_q.size(), 32'd1);
            else check_val("pixel", {24'b0, bus.new_data}, {24'b0, exp_q.pop_front()});
            xfer_cnt++;
            last_xfer_cyc = cyc;
         end
         if (bus.mem_rd_en) begin
            check_val("rd_addr", {16'b0, bus.mem_rd_addr}, {16'b0, AW'(rd_base + rd_cnt)});
            rd_cnt++;
            last_rd_addr = bus.mem_rd_addr;
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         prev_stall = bus.new_data_valid && !bus.in_rd_en;
         prev_data  = bus.new_data;
      end else begin
         prev_stall = 1'b0;
      end
   endtask

   task automatic run_frame(input int dim, input int pad, input int base, input int mode,
                            input int mid_start, input int rst_at, input int rnd_fill);
      int p, k, s, n, bound, rd_snap;
      p = dim + 2 * pad;
      for (int i = 0; i < dim * dim; i++)
         ram[AW'(base + i)] = rnd_fill ? DW'($urandom_range(0, 255)) : DW'(i + 1);
      k = 0;
      for (int r = 0; r < p; r++) begin
         for (int c = 0; c < p; c++) begin
            if (pad != 0 && (r == 0 || r == p - 1 || c == 0 || c == p - 1)) begin
               exp_q.push_back(DW'(0));
            end else begin
               exp_q.push_back(ram[AW'(base + k)]);
               k++;
            end
         end
      end
      xfer_cnt = 0; rd_cnt = 0; done_cnt = 0;
      first_valid_cyc = -1; last_xfer_cyc = -1; done_cyc = -1;
      rd_base = AW'(base);
      rd_mode = mode;
      input_dim = 8'(dim);
      pad_en    = (pad != 0);
      base_addr = AW'(base);
      start     = 1'b1;
      s = cyc;
      step();
      start = 1'b0;
      bound = p * p * 4 + 40;
      n = 0;
      while (n < bound && done_cnt == 0) begin
         if (mid_start != 0 && n == 5) begin
            start = 1'b1; input_dim = 8'd7; pad_en = ~pad_en; base_addr = AW'(base + 100);
         end else begin
            start = 1'b0;
         end
         if (rst_at > 0 && xfer_cnt >= rst_at) begin
            reset = 1'b1;
            step();
            reset = 1'b0;
            check_val("rst_valid", {31'b0, bus.new_data_valid}, 32'd0);
            check_val("rst_busy", {31'b0, busy}, 32'd0);
            check_val("rst_state", {30'b0, dbg_state}, {30'b0, IDLE});
            exp_q.delete();
            rd_snap = rd_cnt;
            repeat (6) step();
            check_val("rst_no_done", done_cnt, 32'd0);
            check_val("rst_no_rd", rd_cnt, rd_snap);
            return;
         end
         step();
         n++;
      end
      start = 1'b0;
      check_val("done_seen", done_cnt, 32'd1);
      check_val("left_in_q", exp_q.size(), 32'd0);
      check_val("rd_count", rd_cnt, dim * dim);
      check_val("xfer_count", xfer_cnt, p * p);
      if (p > 0) begin
         check_val("done_lat", done_cyc - last_xfer_cyc, 32'd1);
         check_val("first_valid", first_valid_cyc - s, 32'd2);
         if (mode == 0) check_val("back2back", last_xfer_cyc - first_valid_cyc, p * p - 1);
      end else begin
         check_val("done_lat0", done_cyc - s, 32'd1);
         check_val("no_valid", first_valid_cyc, 32'hffff_ffff);
      end
      if (dim > 0) check_val("last_rd", {16'b0, last_rd_addr}, {16'b0, AW'(base + dim * dim - 1)});
      step();
      check_val("busy_after", {31'b0, busy}, 32'd0);
      repeat (3) step();
      check_val("single_done", done_cnt, 32'd1);
      exp_q.delete();
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; input_dim = 8'd0; pad_en = 1'b0; base_addr = '0;
      bus.in_rd_en = 1'b1;
      prev_stall = 1'b0; prev_data = '0;
      xfer_cnt = 0; rd_cnt = 0; done_cnt = 0;
      first_valid_cyc = -1; last_xfer_cyc = -1; done_cyc = -1;
      rd_base = '0; last_rd_addr = '0;
      fork
         forever begin
            @(posedge clock);
            cyc++;
         end
         forever begin
            @(posedge clock);
            #1;
            case (rd_mode)
               1:       bus.in_rd_en = ((cyc % 2) == 0);
               2:       bus.in_rd_en = ($urandom_range(0, 1) == 1);
               default: bus.in_rd_en = 1'b1;
            endcase
         end
         forever monitor_cycle();
      join_none

      repeat (3) step();
      check_val("rst_mem_rd_en", {31'b0, bus.mem_rd_en}, 32'd0);
      check_val("rst_mem_rd_addr", {16'b0, bus.mem_rd_addr}, 32'd0);
      check_val("rst_new_data", {24'b0, bus.new_data}, 32'd0);
      check_val("rst_new_valid", {31'b0, bus.new_data_valid}, 32'd0);
      check_val("rst_busy0", {31'b0, busy}, 32'd0);
      check_val("rst_done0", {31'b0, done}, 32'd0);
      check_val("rst_state0", {30'b0, dbg_state}, {30'b0, IDLE});
      reset = 1'b0;
      step();

      run_frame(3, 1, 'h10, 0, 0, 0, 0);
      run_frame(4, 0, 'h200, 1, 0, 0, 1);
      run_frame(0, 0, 'h30, 0, 0, 0, 0);
      run_frame(0, 1, 'h30, 0, 0, 0, 0);
      run_frame(1, 0, 'h40, 2, 0, 0, 1);
      run_frame(1, 1, 'h48, 0, 0, 0, 1);
      run_frame(3, 1, 'h10, 2, 1, 0, 1);
      run_frame(3, 1, 'h10, 0, 0, 10, 0);
      run_frame(3, 1, 'h10, 0, 0, 0, 0);
      run_frame(3, 0, 'hfffc, 0, 0, 0, 1);
      for (int t = 0; t < 4; t++)
         run_frame($urandom_range(1, 12), $urandom_range(0, 1), $urandom_range(0, 65535), 2, 0, 0, 1);
      run_frame(224, 1, 'h100, 0, 0, 0, 1);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
